inst_fetch_axi: RTL and testbench
=================================

Name: inst_fetch_axi

Overview:
- AXI4 read master that fetches one instruction word per request for the IF stage.
- Issues a single-beat read at the current PC whenever the IF/ID stage signals `next_pc_valid`.
- Returns the word as a one-cycle `valid` pulse with `if_pc`/`if_inst`, which IF/ID captures or buffers under stall.
- Flushes discard in-flight fetches without violating AXI ordering.

Parameters:
- ID_WIDTH, 4, width of arid/rid.
- FETCH_ID, 0, constant value driven on arid.
- MAP_KSEG, 1, when 1 translate kseg0/kseg1 virtual addresses to physical (clear addr[31:29] for 0x8000_0000–0xBFFF_FFFF).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low (0 = reset).
- pc  in  32  fetch address from pc_reg.
- pc_excepttype  in  32  exception flags attached to pc; nonzero means do not access the bus.
- next_pc_valid  in  1  request to fetch the instruction at pc.
- flush  in  1  discard the in-flight or pending fetch.
- valid  out  1  one-cycle pulse: if_pc/if_inst/if_excepttype are valid.
- if_pc  out  32  PC of the returned instruction.
- if_inst  out  32  returned instruction word.
- if_excepttype  out  32  pc_excepttype captured at request time.
- busy  out  1  state != IDLE.
- arid  out  ID_WIDTH  = FETCH_ID.
- araddr  out  32  physical fetch address.
- arlen  out  8  = 0.
- arsize  out  3  = 3'b010.
- arburst  out  2  = 2'b01.
- arvalid  out  1  address valid.
- arready  in  1  address accepted.
- rid  in  ID_WIDTH  ignored.
- rdata  in  32  read data.
- rresp  in  2  response; ignored except that a nonzero value forces if_inst = 0.
- rlast  in  1  last beat (always 1 for a single beat).
- rvalid  in  1  data valid.
- rready  out  1  data accept.

Behaviour:
- Reset (rst = 0 at posedge): state IDLE; valid, arvalid, rready = 0; if_pc, if_inst, if_excepttype, araddr = 0; req_pending = 0. Reset in any state aborts immediately; the bench must not drive rvalid for an aborted transaction.
- req_pending:
  - Set when next_pc_valid = 1 in a non-IDLE state.
  - Cleared when consumed or on flush.
  - In IDLE, a request is next_pc_valid OR req_pending.
- State IDLE:
  - On a request with pc_excepttype != 0: no bus access. Next cycle valid = 1, if_pc = pc, if_inst = 0, if_excepttype = pc_excepttype. Stay IDLE.
  - On a request with pc_excepttype == 0: capture pc, pc_excepttype, and translated araddr; set arvalid = 1; go to AR.
  - A request and flush in the same cycle: flush wins and no fetch is started.
- State AR:
  - Hold arvalid and araddr stable until arready. Never drop arvalid early, even on flush.
  - On arready: arvalid = 0, rready = 1. Go to R, or to DROP if flush was seen in AR or occurs in this cycle.
- State R:
  - On rvalid & rlast without flush: next cycle valid = 1, if_pc = captured pc, if_inst = rdata (0 if rresp != 0), if_excepttype = captured value. rready = 0; go to IDLE.
  - On flush without rvalid: go to DROP.
  - On flush in the same cycle as rvalid: discard the data, no valid pulse, go to IDLE.
- State DROP: rready = 1. On rvalid & rlast, discard with no valid pulse, rready = 0, go to IDLE.
- Flush memory: a flush_seen flag records any flush in AR. Flush in IDLE only clears req_pending.
- valid is high for exactly one cycle; if_* hold their last values afterwards.
- Latency:
  - ar handshake at cycle N, rvalid at cycle M → valid at M+1.
  - Zero-wait slave: request at cycle 0 → arvalid at 1 → valid at 3.
- Address translation (MAP_KSEG = 1): 0x8000_0000–0x9FFF_FFFF and 0xA000_0000–0xBFFF_FFFF → addr & 0x1FFF_FFFF. Other ranges pass through unchanged.
- At most one outstanding transaction at any time.

Test Plan:
- Single fetch: rst released; pc = 0xBFC0_0000, next_pc_valid pulse; slave zero-wait, rdata = 0x2408_0001 → araddr = 0x1FC0_0000, valid pulse at cycle 3, if_pc = 0xBFC0_0000, if_inst = 0x2408_0001.
- Backpressure: arready delayed 4 cycles, rvalid delayed 3 → arvalid and araddr stable for all 5 cycles; exactly one valid pulse, one cycle after the rvalid handshake.
- Pending request: second next_pc_valid pulse (pc = 0xBFC0_0004) while in R → second AR issued immediately after the first valid, araddr = 0x1FC0_0004; two valid pulses in order.
- Flush cases: flush in AR before arready, flush in R, and flush coinciding with rvalid → each completes its bus handshake, produces no valid pulse, returns to IDLE; the next fetch works normally.
- Exception bypass: pc = 0xBFC0_0002, pc_excepttype = 0x0000_4000 → no arvalid; valid next cycle with if_inst = 0 and if_excepttype = 0x0000_4000.
- Reset mid-operation: rst = 0 while in R → all outputs 0, state IDLE next cycle; a fetch after reset release completes correctly.

Source files
------------

// File: rtl/inst_fetch_axi_if.sv
// AXI4 read channels (AR + R) between the fetch unit and memory.
// master: fetch unit drives ar*/rready; slave: memory drives arready/r*.
interface inst_fetch_axi_if #(
  parameter int ID_WIDTH = 4
);
  logic [ID_WIDTH-1:0] arid;
  logic [31:0]         araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_WIDTH-1:0] rid;
  logic [31:0]         rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst,
    output arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst,
    input  arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/inst_fetch_axi.sv
// Single-beat AXI4 instruction fetch master for the IF stage.
// Ports: clk, rst (sync, active-low); pc/pc_excepttype/next_pc_valid/flush
// from the PC side; valid/if_pc/if_inst/if_excepttype/busy to IF/ID;
// axi: AR/R master channels (one outstanding read at most).
module inst_fetch_axi #(
  parameter int ID_WIDTH = 4,
  parameter int FETCH_ID = 0,
  parameter bit MAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic [31:0] pc_excepttype,
  input  logic        next_pc_valid,
  input  logic        flush,
  output logic        valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] if_excepttype,
  output logic        busy,
  inst_fetch_axi_if.master axi
);

  typedef enum logic [1:0] {
    IDLE,
    AR,
    R,
    DROP
  } state_t;

  state_t      state;
  logic [31:0] araddr;
  logic        arvalid;
  logic        rready;
  logic        req_pending;
  logic        flush_seen;
  logic [31:0] cap_pc;
  logic [31:0] cap_exc;
  logic        req;
  logic        unused_rid;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto the low 512 MB.
  function automatic logic [31:0] phys(input logic [31:0] va);
    if (MAP_KSEG && va[31:30] == 2'b10) begin
      return {3'b000, va[28:0]};
    end
    return va;
  endfunction

  assign req  = next_pc_valid | req_pending;
  assign busy = (state != IDLE);

  assign axi.arid    = ID_WIDTH'(FETCH_ID);
  assign axi.araddr  = araddr;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;

  assign unused_rid = ^axi.rid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      valid         <= 1'b0;
      if_pc         <= 32'd0;
      if_inst       <= 32'd0;
      if_excepttype <= 32'd0;
      araddr        <= 32'd0;
      arvalid       <= 1'b0;
      rready        <= 1'b0;
      req_pending   <= 1'b0;
      flush_seen    <= 1'b0;
      cap_pc        <= 32'd0;
      cap_exc       <= 32'd0;
    end else begin
      valid <= 1'b0;

      // A request arriving mid-transaction is remembered for IDLE.
      if (flush) begin
        req_pending <= 1'b0;
      end else if (next_pc_valid && state != IDLE) begin
        req_pending <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (!flush && req) begin
            req_pending <= 1'b0;
            if (pc_excepttype != 32'd0) begin
              valid         <= 1'b1;
              if_pc         <= pc;
              if_inst       <= 32'd0;
              if_excepttype <= pc_excepttype;
            end else begin
              cap_pc     <= pc;
              cap_exc    <= pc_excepttype;
              araddr     <= phys(pc);
              arvalid    <= 1'b1;
              flush_seen <= 1'b0;
              state      <= AR;
            end
          end
        end
        AR: begin
          // arvalid must stay up until accepted; a flush is only noted.
          if (flush) begin
            flush_seen <= 1'b1;
          end
          if (axi.arready) begin
            arvalid    <= 1'b0;
            rready     <= 1'b1;
            flush_seen <= 1'b0;
            state      <= (flush_seen || flush) ? DROP : R;
          end
        end
        R: begin
          if (axi.rvalid && axi.rlast) begin
            rready <= 1'b0;
            state  <= IDLE;
            if (!flush) begin
              valid         <= 1'b1;
              if_pc         <= cap_pc;
              if_inst       <= (axi.rresp != 2'b00) ? 32'd0 : axi.rdata;
              if_excepttype <= cap_exc;
            end
          end else if (flush) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (axi.rvalid && axi.rlast) begin
            rready <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_axi.sv
// Directed bench for inst_fetch_axi with a delay-programmable AXI slave.
// Outputs sampled on negedge; slave reacts just after posedge.
module tb_inst_fetch_axi;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [31:0] pc_excepttype = 32'd0;
  logic        next_pc_valid = 1'b0;
  logic        flush = 1'b0;
  logic        valid;
  logic        busy;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_excepttype;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  inst_fetch_axi_if #(.ID_WIDTH(4)) axi ();

  inst_fetch_axi #(
    .ID_WIDTH(4),
    .FETCH_ID(0),
    .MAP_KSEG(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .pc_excepttype(pc_excepttype),
    .next_pc_valid(next_pc_valid),
    .flush(flush),
    .valid(valid),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .if_excepttype(if_excepttype),
    .busy(busy),
    .axi(axi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          ar_delay = 0;
  int          r_delay = 0;
  int          ph = 0;
  int          cnt = 0;
  int          unstable = 0;
  int          perr = 0;
  int          rv_cyc = 0;
  int          arh_cyc = 0;
  logic [31:0] cur_addr = 32'd0;
  logic [31:0] ar_q[$];
  int          arst_q[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h1FC0_0000: return 32'h2408_0001;
      32'h1FC0_0004: return 32'h2529_0002;
      default:       return a;
    endcase
  endfunction

  initial begin
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rdata   = 32'd0;
    axi.rresp   = 2'b00;
    axi.rlast   = 1'b0;
    axi.rid     = 4'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        ph = 0;
        cnt = 0;
        axi.arready = 1'b0;
        axi.rvalid = 1'b0;
        axi.rlast = 1'b0;
      end else begin
        if (ph == 2 && axi.rvalid) begin
          axi.rvalid = 1'b0;
          axi.rlast = 1'b0;
          ph = 0;
        end
        if (ph == 1 && axi.arready) begin
          axi.arready = 1'b0;
          ar_q.push_back(cur_addr);
          ph = 2;
          cnt = 0;
        end
        if (ph == 0 && axi.arvalid) begin
          cur_addr = axi.araddr;
          arst_q.push_back(cyc);
          ph = 1;
          cnt = 0;
        end else if (ph == 1 &&
                     (!axi.arvalid || axi.araddr != cur_addr)) begin
          unstable++;
        end
        if (ph == 1 && !axi.arready) begin
          if (cnt >= ar_delay) begin
            axi.arready = 1'b1;
            arh_cyc = cyc;
          end else begin
            cnt++;
          end
        end
        if (ph == 2 && !axi.rvalid) begin
          if (cnt >= r_delay) begin
            axi.rvalid = 1'b1;
            axi.rlast = 1'b1;
            axi.rdata = mem(cur_addr);
            axi.rresp = (cur_addr == 32'h1FC0_0010) ? 2'b10 : 2'b00;
            rv_cyc = cyc;
            if (!axi.rready) perr++;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  // ---------------- valid monitor ----------------
  logic [31:0] v_pc_q[$];
  logic [31:0] v_inst_q[$];
  logic [31:0] v_exc_q[$];
  int          v_cyc_q[$];
  int          wide = 0;
  logic        vprev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (valid) begin
        v_pc_q.push_back(if_pc);
        v_inst_q.push_back(if_inst);
        v_exc_q.push_back(if_excepttype);
        v_cyc_q.push_back(cyc);
        if (vprev) wide++;
      end
      vprev = valid;
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse_req(input logic [31:0] a, input logic [31:0] e,
                           output int c0);
    @(negedge clk);
    pc = a;
    pc_excepttype = e;
    next_pc_valid = 1'b1;
    c0 = cyc;
    @(negedge clk);
    next_pc_valid = 1'b0;
    pc_excepttype = 32'd0;
  endtask

  task automatic wait_pulses(input int n, input string tag);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      #1;
      if (v_pc_q.size() >= n) break;
    end
    check(tag, 32'(v_pc_q.size()), 32'(n));
  endtask

  // mode 0: AR waiting, 1: R waiting for data, 2: rvalid up
  task automatic wait_for(input int mode, input string tag);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 60 && !hit; k++) begin
      @(negedge clk);
      case (mode)
        0:       hit = axi.arvalid && !axi.arready;
        1:       hit = axi.rready && !axi.rvalid;
        default: hit = axi.rvalid;
      endcase
    end
    check(tag, {31'd0, hit}, 32'd1);
  endtask

  task automatic settle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      #1;
      done = !busy && ph == 0;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] ea,
                          input logic [31:0] ei, input int lat,
                          input string tag);
    int n;
    int arn;
    int c0;
    n = v_pc_q.size();
    arn = ar_q.size();
    pulse_req(a, 32'd0, c0);
    wait_pulses(n + 1, {tag, "_cnt"});
    check({tag, "_araddr"}, ar_q[arn], ea);
    check({tag, "_pc"}, v_pc_q[n], a);
    check({tag, "_inst"}, v_inst_q[n], ei);
    check({tag, "_exc"}, v_exc_q[n], 32'd0);
    check({tag, "_lat"}, 32'(v_cyc_q[n] - c0), 32'(lat));
    settle({tag, "_idle"});
  endtask

  task automatic reset_outs(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_arvalid"}, 32'(axi.arvalid), 32'd0);
    check({tag, "_rready"}, 32'(axi.rready), 32'd0);
    check({tag, "_araddr"}, axi.araddr, 32'd0);
    check({tag, "_if_pc"}, if_pc, 32'd0);
    check({tag, "_if_inst"}, if_inst, 32'd0);
    check({tag, "_if_exc"}, if_excepttype, 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int n;
  int arn;
  int c0;

  initial begin
    repeat (3) @(negedge clk);
    reset_outs("rst");
    check("rst_arlen", 32'(axi.arlen), 32'd0);
    check("rst_arsize", 32'(axi.arsize), 32'd2);
    check("rst_arburst", 32'(axi.arburst), 32'd1);
    check("rst_arid", 32'(axi.arid), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_fetch(32'hBFC0_0000, 32'h1FC0_0000, 32'h2408_0001, 3, "single");

    // backpressure: arready after 4 wait cycles, rvalid after 3
    ar_delay = 4;
    r_delay = 3;
    n = v_pc_q.size();
    pulse_req(32'hBFC0_0008, 32'd0, c0);
    wait_pulses(n + 1, "bp_cnt");
    check("bp_stable", 32'(unstable), 32'd0);
    check("bp_ar_len", 32'(arh_cyc - arst_q[arst_q.size() - 1]), 32'd4);
    check("bp_araddr", ar_q[ar_q.size() - 1], 32'h1FC0_0008);
    check("bp_inst", v_inst_q[n], 32'h1FC0_0008);
    check("bp_rv_lat", 32'(v_cyc_q[n] - rv_cyc), 32'd1);
    check("bp_lat", 32'(v_cyc_q[n] - c0), 32'd10);
    settle("bp_idle");
    repeat (4) @(negedge clk);
    check("bp_single", 32'(v_pc_q.size()), 32'(n + 1));

    // pending request raised while in R
    ar_delay = 0;
    r_delay = 3;
    n = v_pc_q.size();
    arn = ar_q.size();
    pulse_req(32'hBFC0_0000, 32'd0, c0);
    wait_for(1, "pend_inR");
    pc = 32'hBFC0_0004;
    next_pc_valid = 1'b1;
    @(negedge clk);
    next_pc_valid = 1'b0;
    wait_pulses(n + 2, "pend_cnt");
    check("pend_ar0", ar_q[arn], 32'h1FC0_0000);
    check("pend_ar1", ar_q[arn + 1], 32'h1FC0_0004);
    check("pend_pc0", v_pc_q[n], 32'hBFC0_0000);
    check("pend_inst0", v_inst_q[n], 32'h2408_0001);
    check("pend_pc1", v_pc_q[n + 1], 32'hBFC0_0004);
    check("pend_inst1", v_inst_q[n + 1], 32'h2529_0002);
    check("pend_lat0", 32'(v_cyc_q[n] - c0), 32'd6);
    check("pend_ar_gap", 32'(arst_q[arst_q.size() - 1] - v_cyc_q[n]),
          32'd1);
    settle("pend_idle");

    // flushes in AR, in R, and together with rvalid
    for (int m = 0; m < 3; m++) begin
      ar_delay = (m == 0) ? 3 : 0;
      r_delay = (m == 0) ? 1 : ((m == 1) ? 3 : 2);
      n = v_pc_q.size();
      arn = ar_q.size();
      pulse_req(32'hBFC0_0000, 32'd0, c0);
      wait_for(m, $sformatf("fl%0d_wait", m));
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      settle($sformatf("fl%0d_idle", m));
      repeat (3) @(negedge clk);
      check($sformatf("fl%0d_nopulse", m), 32'(v_pc_q.size()), 32'(n));
      check($sformatf("fl%0d_ar_done", m), 32'(ar_q.size()),
            32'(arn + 1));
      ar_delay = 0;
      r_delay = 0;
      do_fetch(32'hBFC0_0004, 32'h1FC0_0004, 32'h2529_0002, 3,
               $sformatf("fl%0d_after", m));
    end

    // exception bypass
    n = v_pc_q.size();
    arn = arst_q.size();
    pulse_req(32'hBFC0_0002, 32'h0000_4000, c0);
    wait_pulses(n + 1, "exc_cnt");
    check("exc_pc", v_pc_q[n], 32'hBFC0_0002);
    check("exc_inst", v_inst_q[n], 32'd0);
    check("exc_type", v_exc_q[n], 32'h0000_4000);
    check("exc_lat", 32'(v_cyc_q[n] - c0), 32'd1);
    repeat (3) @(negedge clk);
    check("exc_no_ar", 32'(arst_q.size()), 32'(arn));

    // error response, kseg2 and kuseg pass-through
    do_fetch(32'hBFC0_0010, 32'h1FC0_0010, 32'd0, 3, "rresp");
    do_fetch(32'hC000_0100, 32'hC000_0100, 32'hC000_0100, 3, "kseg2");
    do_fetch(32'h0040_0000, 32'h0040_0000, 32'h0040_0000, 3, "kuseg");

    // reset while waiting for read data
    ar_delay = 0;
    r_delay = 4;
    n = v_pc_q.size();
    pulse_req(32'hBFC0_0008, 32'd0, c0);
    wait_for(1, "mid_inR");
    rst = 1'b0;
    @(negedge clk);
    reset_outs("mid");
    rst = 1'b1;
    repeat (6) @(negedge clk);
    check("mid_nopulse", 32'(v_pc_q.size()), 32'(n));
    r_delay = 0;
    do_fetch(32'hBFC0_0000, 32'h1FC0_0000, 32'h2408_0001, 3, "post_rst");

    check("valid_width", 32'(wide), 32'd0);
    check("r_protocol", 32'(perr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
